scp079: RTL and testbench

- Moore state machine that monitors a one-hot traffic-light style colour input (green/yellow/red) together with an externally supplied tick count `timer`.
- Escalates through normal, standby, alert, caution and lockdown states, driving three alarm lines and a cheat/illegal-input flag.
- Sits between the colour-source logic and the alarm/indicator logic.
- Owns no counter: the time base is external.

---
 rtl/scp079_pkg.sv | 28 ++
 rtl/scp079_color_check.sv | 26 ++
 rtl/scp079.sv | 91 +++++++++
 tb/tb_scp079.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/scp079_pkg.sv
// scp079_pkg: shared types and default thresholds for the scp079 escalation FSM.
//   state_e  - 3-bit state codes (codes 5-7 unused/illegal)
//   colour_e - decoded colour request from scp079_color_check
//   T_*_DEF  - default timer thresholds
package scp079_pkg;

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        ALERT    = 3'd1,
        STANDBY  = 3'd2,
        CAUTION  = 3'd3,
        LOCKDOWN = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        COL_NONE   = 2'd0,
        COL_GREEN  = 2'd1,
        COL_YELLOW = 2'd2,
        COL_RED    = 2'd3
    } colour_e;

    localparam logic [5:0] T_GREEN_DEF   = 6'd35;
    localparam logic [5:0] T_STANDBY_DEF = 6'd5;
    localparam logic [5:0] T_RED_DEF     = 6'd25;
    localparam logic [5:0] T_YELLOW_DEF  = 6'd20;
    localparam logic [5:0] T_LOCK_DEF    = 6'd12;

endpackage

// File: rtl/scp079_color_check.sv
// scp079_color_check: combinational one-hot check of the colour inputs.
//   green/yellow/red - raw colour requests
//   valid            - exactly one colour is high
//   colour           - decoded colour, COL_NONE whenever valid is low
module scp079_color_check
    import scp079_pkg::*;
(
    input  logic    green,
    input  logic    yellow,
    input  logic    red,
    output logic    valid,
    output colour_e colour
);

    always_comb begin
        valid  = 1'b0;
        colour = COL_NONE;
        unique case ({green, yellow, red})
            3'b100: begin valid = 1'b1; colour = COL_GREEN;  end
            3'b010: begin valid = 1'b1; colour = COL_YELLOW; end
            3'b001: begin valid = 1'b1; colour = COL_RED;    end
            default: begin valid = 1'b0; colour = COL_NONE;  end
        endcase
    end

endmodule

// File: rtl/scp079.sv
// scp079: Moore escalation FSM driven by a one-hot colour request and an
// externally supplied tick count.
//   clock, reset     - system clock, asynchronous active-high reset
//   green/yellow/red - colour requests (exactly one high is valid)
//   timer            - external tick count, restarted by the environment
//   state            - registered state code
//   a1/a2/a3         - standby / alert / lockdown alarms
//   cheat_out        - registered illegal-colour flag
module scp079
    import scp079_pkg::*;
#(
    parameter logic [5:0] T_GREEN   = T_GREEN_DEF,
    parameter logic [5:0] T_STANDBY = T_STANDBY_DEF,
    parameter logic [5:0] T_RED     = T_RED_DEF,
    parameter logic [5:0] T_YELLOW  = T_YELLOW_DEF,
    parameter logic [5:0] T_LOCK    = T_LOCK_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    input  logic [5:0] timer,
    output logic [2:0] state,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       cheat_out
);

    logic       valid;
    colour_e    colour;
    logic [2:0] state_d, state_q;
    logic       cheat_d, cheat_q;

    scp079_color_check u_color_check (
        .green  (green),
        .yellow (yellow),
        .red    (red),
        .valid  (valid),
        .colour (colour)
    );

    always_comb begin
        state_d = state_q;
        cheat_d = ~valid;
        case (state_q)
            NORMAL: if (valid) begin
                if (colour == COL_RED)                            state_d = ALERT;
                else if (colour == COL_YELLOW)                    state_d = CAUTION;
                else if (colour == COL_GREEN && timer >= T_GREEN) state_d = STANDBY;
            end
            STANDBY: if (valid) begin
                if (colour == COL_RED)                              state_d = ALERT;
                else if (colour == COL_YELLOW)                      state_d = CAUTION;
                else if (colour == COL_GREEN && timer >= T_STANDBY) state_d = NORMAL;
            end
            ALERT: if (valid) begin
                if (colour == COL_GREEN)                        state_d = NORMAL;
                else if (colour == COL_YELLOW)                  state_d = CAUTION;
                else if (colour == COL_RED && timer >= T_RED)   state_d = LOCKDOWN;
            end
            CAUTION: if (valid) begin
                if (colour == COL_GREEN)                            state_d = NORMAL;
                else if (colour == COL_RED)                         state_d = ALERT;
                else if (colour == COL_YELLOW && timer >= T_YELLOW) state_d = ALERT;
            end
            // Lockdown releases on time alone; colour only affects cheat_out.
            LOCKDOWN: if (timer >= T_LOCK) state_d = NORMAL;
            // Illegal codes recover unconditionally.
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            cheat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cheat_q <= cheat_d;
        end
    end

    assign state     = state_q;
    assign cheat_out = cheat_q;
    assign a1        = (state_q == STANDBY);
    assign a2        = (state_q == ALERT);
    assign a3        = (state_q == LOCKDOWN);

endmodule

// File: tb/tb_scp079.sv
// tb_scp079: directed self-checking bench for scp079.
module tb_scp079;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       green = 1'b0;
    logic       yellow = 1'b0;
    logic       red = 1'b0;
    logic [5:0] timer = 6'd0;
    logic [2:0] state;
    logic       a1, a2, a3, cheat_out;

    int n_assert = 0;
    int n_fail   = 0;

    scp079 dut (
        .clock     (clock),
        .reset     (reset),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .timer     (timer),
        .state     (state),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .cheat_out (cheat_out)
    );

    always #5 clock = ~clock;

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic g, input logic y, input logic r, input logic [5:0] t);
        @(negedge clock);
        green = g; yellow = y; red = r; timer = t;
        @(posedge clock);
        #1;
    endtask

    // Expected alarms: {a3,a2,a1} is one-hot for LOCKDOWN/ALERT/STANDBY, else zero.
    task automatic chk(input string tag, input logic [2:0] es, input logic [2:0] ealm, input logic ec);
        n_assert++;
        assert (state === es) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, es);
        end
        n_assert++;
        assert ({a3, a2, a1} === ealm) else begin
            n_fail++;
            $error("FAIL %s alarms{a3,a2,a1}: got %b expected %b", tag, {a3, a2, a1}, ealm);
        end
        n_assert++;
        assert (cheat_out === ec) else begin
            n_fail++;
            $error("FAIL %s cheat_out: got %b expected %b", tag, cheat_out, ec);
        end
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset", 3'd0, 3'b000, 1'b0);

        // NORMAL, green ramp: holds through 34, STANDBY after 35
        for (int t = 1; t <= 34; t++) begin
            step(1, 0, 0, 6'(t));
            chk("normal_green_ramp", 3'd0, 3'b000, 1'b0);
        end
        step(1, 0, 0, 6'd35);
        chk("normal_to_standby", 3'd2, 3'b001, 1'b0);

        // STANDBY, green restart: holds through 4, NORMAL after 5
        for (int t = 1; t <= 4; t++) begin
            step(1, 0, 0, 6'(t));
            chk("standby_hold", 3'd2, 3'b001, 1'b0);
        end
        step(1, 0, 0, 6'd5);
        chk("standby_to_normal", 3'd0, 3'b000, 1'b0);

        // Back to STANDBY, then red -> ALERT
        step(1, 0, 0, 6'd35);
        chk("normal_to_standby2", 3'd2, 3'b001, 1'b0);
        step(0, 0, 1, 6'd0);
        chk("standby_red_alert", 3'd1, 3'b010, 1'b0);

        // ALERT, red held: LOCKDOWN after 25
        for (int t = 1; t <= 24; t++) begin
            step(0, 0, 1, 6'(t));
            chk("alert_hold", 3'd1, 3'b010, 1'b0);
        end
        step(0, 0, 1, 6'd25);
        chk("alert_to_lockdown", 3'd4, 3'b100, 1'b0);

        // LOCKDOWN: holds through 11 (colours irrelevant), releases at 12
        for (int t = 1; t <= 10; t++) begin
            step(0, 0, 1, 6'(t));
            chk("lockdown_hold", 3'd4, 3'b100, 1'b0);
        end
        step(0, 0, 0, 6'd11);
        chk("lockdown_nocolour", 3'd4, 3'b100, 1'b1);
        step(1, 0, 1, 6'd12);
        chk("lockdown_release_invalid", 3'd0, 3'b000, 1'b1);
        step(1, 0, 0, 6'd0);
        chk("normal_clean", 3'd0, 3'b000, 1'b0);

        // Invalid colour in NORMAL with timer past threshold: holds, cheat set
        step(1, 0, 1, 6'd40);
        chk("normal_green_red", 3'd0, 3'b000, 1'b1);
        step(1, 1, 1, 6'd40);
        chk("normal_all_three", 3'd0, 3'b000, 1'b1);
        step(1, 0, 0, 6'd0);
        chk("normal_cheat_clear", 3'd0, 3'b000, 1'b0);

        // yellow -> CAUTION (no alarm); yellow held -> ALERT at 20
        step(0, 1, 0, 6'd0);
        chk("normal_to_caution", 3'd3, 3'b000, 1'b0);
        for (int t = 1; t <= 19; t++) begin
            step(0, 1, 0, 6'(t));
            chk("caution_hold", 3'd3, 3'b000, 1'b0);
        end
        step(0, 1, 0, 6'd20);
        chk("caution_to_alert", 3'd1, 3'b010, 1'b0);

        // ALERT yellow -> CAUTION, invalid in CAUTION holds, red -> ALERT, green -> NORMAL
        step(0, 1, 0, 6'd0);
        chk("alert_to_caution", 3'd3, 3'b000, 1'b0);
        step(0, 1, 1, 6'd30);
        chk("caution_invalid_hold", 3'd3, 3'b000, 1'b1);
        step(0, 0, 1, 6'd0);
        chk("caution_red_alert", 3'd1, 3'b010, 1'b0);
        step(1, 0, 0, 6'd0);
        chk("alert_green_normal", 3'd0, 3'b000, 1'b0);

        // Timer wrap value 63 treated as ordinary: >= T_GREEN
        step(1, 0, 0, 6'd63);
        chk("normal_timer63", 3'd2, 3'b001, 1'b0);
        step(1, 0, 0, 6'd4);
        chk("standby_below_thr", 3'd2, 3'b001, 1'b0);

        // Async reset mid-cycle while in ALERT with cheat set
        step(0, 0, 1, 6'd0);
        chk("standby_red_alert2", 3'd1, 3'b010, 1'b0);
        step(0, 0, 0, 6'd3);
        chk("alert_nocolour", 3'd1, 3'b010, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 3'd0, 3'b000, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step(0, 1, 0, 6'd0);
        chk("post_reset_caution", 3'd3, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
